stdp_edge_update_ctrl: RTL and testbench

- Sequences the probabilistic STDP weight update across all synapses of one neuron after each gamma cycle.
- Per synapse:
  - classifies the spike-timing case;
  - selects the matching 7-bit update probability and direction;
  - compares the probability against an internal 7-bit LFSR;
  - read-modify-writes the synaptic weight memory with saturation.
- Sits between the neuron's gamma-cycle spike logic and the per-neuron weight RAM.

---
 rtl/stdp_edge_update_ctrl.sv | 174 +++++++++++++++++
 tb/tb_stdp_edge_update_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_edge_update_ctrl.sv
// stdp_edge_update_ctrl
// Runs one probabilistic STDP weight-update pass over all synapses of a
// neuron. Each synapse takes three cycles: read the weight, draw a random
// number, conditionally write the saturated +/-1 result back.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle pass request (honoured only in IDLE)
//   in_spike, in_early         per-synapse timing flags, latched on start
//   out_spike                  neuron fired this gamma cycle, latched on start
//   u_capture/minus/search/backoff  7-bit update probabilities (x/128)
//   busy                       pass in progress
//   done                       one-cycle pulse marking the end of a pass
//   wt_addr, wt_re, wt_rdata   weight RAM read port (1-cycle read latency)
//   wt_we, wt_wdata            weight RAM write port
//
// state | meaning
// IDLE  | waiting for start, LFSR frozen
// READ  | wt_re high for synapse idx, LFSR steps once
// WAIT  | read data returns; hit/direction decided, write data registered
// WRITE | wt_we high if the update applies; advance idx or finish
// DONE  | done pulse, busy low, idx back to 0
module stdp_edge_update_ctrl #(
   parameter int         NUM_SYN   = 16,
   parameter int         W_BITS    = 3,
   parameter logic [6:0] LFSR_SEED = 7'h5A
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_SYN-1:0]         in_spike,
   input  logic [NUM_SYN-1:0]         in_early,
   input  logic                       out_spike,
   input  logic [6:0]                 u_capture,
   input  logic [6:0]                 u_minus,
   input  logic [6:0]                 u_search,
   input  logic [6:0]                 u_backoff,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(NUM_SYN)-1:0] wt_addr,
   output logic                       wt_re,
   input  logic [W_BITS-1:0]          wt_rdata,
   output logic                       wt_we,
   output logic [W_BITS-1:0]          wt_wdata
);

   localparam int                AW    = $clog2(NUM_SYN);
   localparam logic [AW-1:0]     LAST  = AW'(NUM_SYN - 1);
   localparam logic [W_BITS-1:0] W_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state;
   logic [AW-1:0]      idx;
   logic [6:0]         lfsr;
   logic [NUM_SYN-1:0] sh_spike;
   logic [NUM_SYN-1:0] sh_early;
   logic               sh_out;
   logic [6:0]         sh_ucap;
   logic [6:0]         sh_umin;
   logic [6:0]         sh_usea;
   logic [6:0]         sh_uback;

   logic [2:0]         case_code;
   logic [6:0]         prob;
   logic               inc;
   logic               dec;
   logic               hit;
   logic [6:0]         lfsr_next;

   // x^7 + x^6 + 1, shift left with feedback into bit 0
   assign lfsr_next = {lfsr[5:0], lfsr[6] ^ lfsr[5]};

   always_comb begin
      case_code = {sh_spike[idx], sh_out, sh_early[idx] & sh_spike[idx] & sh_out};
      prob      = 7'd0;
      inc       = 1'b0;
      dec       = 1'b0;
      case (case_code)
         3'b010: begin prob = sh_uback; dec = 1'b1; end
         3'b100: begin prob = sh_usea;  inc = 1'b1; end
         3'b110: begin prob = sh_umin;  dec = 1'b1; end
         3'b111: begin prob = sh_ucap;  inc = 1'b1; end
         default: begin prob = 7'd0; end
      endcase
   end

   // Evaluated in WAIT: the LFSR stepped at the end of READ, so its current
   // value is this synapse's draw. Deciding here lets wt_we/wt_wdata be
   // registered straight into the WRITE cycle.
   assign hit = (lfsr < prob);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         lfsr     <= LFSR_SEED;
         busy     <= 1'b0;
         done     <= 1'b0;
         wt_addr  <= '0;
         wt_re    <= 1'b0;
         wt_we    <= 1'b0;
         wt_wdata <= '0;
         sh_spike <= '0;
         sh_early <= '0;
         sh_out   <= 1'b0;
         sh_ucap  <= '0;
         sh_umin  <= '0;
         sh_usea  <= '0;
         sh_uback <= '0;
      end else begin
         done  <= 1'b0;
         wt_re <= 1'b0;
         wt_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sh_spike <= in_spike;
                  sh_early <= in_early;
                  sh_out   <= out_spike;
                  sh_ucap  <= u_capture;
                  sh_umin  <= u_minus;
                  sh_usea  <= u_search;
                  sh_uback <= u_backoff;
                  idx      <= '0;
                  wt_addr  <= '0;
                  wt_re    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_READ;
               end
            end
            S_READ: begin
               lfsr  <= lfsr_next;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (hit && inc && (wt_rdata != W_MAX)) begin
                  wt_we    <= 1'b1;
                  wt_wdata <= wt_rdata + 1'b1;
               end else if (hit && dec && (wt_rdata != '0)) begin
                  wt_we    <= 1'b1;
                  wt_wdata <= wt_rdata - 1'b1;
               end
               state <= S_WRITE;
            end
            S_WRITE: begin
               if (idx == LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  idx     <= idx + 1'b1;
                  wt_addr <= idx + 1'b1;
                  wt_re   <= 1'b1;
                  state   <= S_READ;
               end
            end
            S_DONE: begin
               idx     <= '0;
               wt_addr <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stdp_edge_update_ctrl.sv
// Bench for stdp_edge_update_ctrl: a behavioural weight RAM, a bit-exact
// LFSR/update model feeding an expected-write queue, and a table of passes.
`timescale 1ns/1ps
module tb_stdp_edge_update_ctrl;
   localparam int N  = 16;
   localparam int WB = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  in_spike = '0;
   logic [N-1:0]  in_early = '0;
   logic          out_spike = 1'b0;
   logic [6:0]    u_capture = '0, u_minus = '0, u_search = '0, u_backoff = '0;
   logic          busy, done, wt_re, wt_we;
   logic [3:0]    wt_addr;
   logic [WB-1:0] wt_rdata = '0;
   logic [WB-1:0] wt_wdata;

   always #5 clk = ~clk;

   stdp_edge_update_ctrl #(.NUM_SYN(N), .W_BITS(WB), .LFSR_SEED(7'h5A)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_spike(in_spike), .in_early(in_early), .out_spike(out_spike),
      .u_capture(u_capture), .u_minus(u_minus), .u_search(u_search), .u_backoff(u_backoff),
      .busy(busy), .done(done),
      .wt_addr(wt_addr), .wt_re(wt_re), .wt_rdata(wt_rdata),
      .wt_we(wt_we), .wt_wdata(wt_wdata)
   );

   // weight RAM with one-cycle read latency and a bench-side bulk preload
   logic [WB-1:0] ram [N];
   logic          pre_en = 1'b0;
   logic [WB-1:0] pre_val = '0;
   always @(posedge clk) begin
      if (pre_en) begin
         for (int k = 0; k < N; k++) ram[k] <= pre_val;
      end else if (wt_we) begin
         ram[wt_addr] <= wt_wdata;
      end
      if (wt_re) wt_rdata <= ram[wt_addr];
   end

   typedef struct packed {
      logic [3:0]    addr;
      logic [WB-1:0] data;
   } wr_t;

   typedef struct {
      logic [N-1:0]  sp;
      logic [N-1:0]  ea;
      logic          os;
      logic [6:0]    uc, um, us, ub;
      bit            load;
      logic [WB-1:0] pre;
      int            tgt;
      logic [WB-1:0] exp_tgt;
   } vec_t;

   wr_t           exp_q[$];
   logic [WB-1:0] model_mem [N];
   logic [6:0]    m_draw [N];
   logic [6:0]    m_lfsr = 7'h5A;
   int            n_checks = 0, n_errors = 0;
   int            rd_expect = 0, wr_seen = 0, n_wr_exp = 0, done_cnt = 0;
   vec_t          vecs [8];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] lfsr_step(input logic [6:0] l);
      return {l[5:0], l[6] ^ l[5]};
   endfunction

   // Monitor: reads in order, strobe exclusivity, writes against the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (wt_re || wt_we) chk("strobe_excl", int'(wt_re & wt_we), 0);
         if (wt_re) begin
            chk("rd_addr", int'(wt_addr), rd_expect);
            rd_expect++;
         end
         if (wt_we) begin
            wr_t e;
            wr_seen++;
            if (exp_q.size() == 0) chk("wr_unexpected_addr", int'(wt_addr), -1);
            else begin
               e = exp_q.pop_front();
               chk("wr_addr", int'(wt_addr), int'(e.addr));
               chk("wr_data", int'(wt_wdata), int'(e.data));
            end
         end
      end
   end

   task automatic preload(input logic [WB-1:0] v);
      pre_en  = 1'b1;
      pre_val = v;
      @(negedge clk);
      pre_en  = 1'b0;
      for (int k = 0; k < N; k++) model_mem[k] = v;
   endtask

   // Expected outcome of a pass from the latched inputs and the model LFSR.
   task automatic plan_pass(input vec_t v);
      n_wr_exp = 0;
      for (int i = 0; i < N; i++) begin
         logic [2:0] c;
         logic [6:0] p;
         int         dir;
         m_lfsr    = lfsr_step(m_lfsr);
         m_draw[i] = m_lfsr;
         c = {v.sp[i], v.os, v.ea[i] & v.sp[i] & v.os};
         case (c)
            3'b010:  begin p = v.ub; dir = -1; end
            3'b100:  begin p = v.us; dir = 1;  end
            3'b110:  begin p = v.um; dir = -1; end
            3'b111:  begin p = v.uc; dir = 1;  end
            default: begin p = 7'd0; dir = 0;  end
         endcase
         if (m_lfsr < p) begin
            if (dir == 1 && model_mem[i] != 3'd7) begin
               model_mem[i] = model_mem[i] + 3'd1;
               exp_q.push_back({4'(i), model_mem[i]});
               n_wr_exp++;
            end else if (dir == -1 && model_mem[i] != 3'd0) begin
               model_mem[i] = model_mem[i] - 3'd1;
               exp_q.push_back({4'(i), model_mem[i]});
               n_wr_exp++;
            end
         end
      end
   endtask

   task automatic drive_inputs(input vec_t v);
      in_spike  = v.sp;
      in_early  = v.ea;
      out_spike = v.os;
      u_capture = v.uc;
      u_minus   = v.um;
      u_search  = v.us;
      u_backoff = v.ub;
   endtask

   // Called at a negedge; start is sampled at the following posedge.
   // Latency is counted inclusively: start cycle .. done cycle.
   task automatic run_pass(input vec_t v, input bit noisy);
      int cyc;
      int d0;
      int mism;
      bit got;
      plan_pass(v);
      drive_inputs(v);
      rd_expect = 0;
      wr_seen   = 0;
      d0        = done_cnt;
      start     = 1'b1;
      cyc       = 0;
      got       = 1'b0;
      while (cyc < 200 && !got) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == 1) begin
            chk("busy_after_start", int'(busy), 1);
            chk("first_rd_addr", int'(wt_addr), 0);
            chk("first_rd_re", int'(wt_re), 1);
         end
         if (noisy && (cyc == 5 || cyc == 20)) begin
            start     = 1'b1;
            in_spike  = N'($urandom);
            in_early  = N'($urandom);
            out_spike = ~out_spike;
            u_capture = 7'($urandom);
            u_minus   = 7'($urandom);
            u_search  = 7'($urandom);
            u_backoff = 7'($urandom);
         end
         if (done) got = 1'b1;
      end
      chk("done_seen", int'(got), 1);
      if (got) chk("latency", cyc + 1, 3 * N + 2);
      chk("busy_at_done", int'(busy), 0);
      chk("reads", rd_expect, N);
      chk("writes", wr_seen, n_wr_exp);
      chk("writes_pending", exp_q.size(), 0);
      chk("lfsr", int'(dut.lfsr), int'(m_lfsr));
      mism = 0;
      for (int k = 0; k < N; k++) if (ram[k] !== model_mem[k]) mism++;
      chk("ram_image", mism, 0);
      if (noisy) begin
         start = 1'b1;               // coincides with done: must be ignored
         @(negedge clk);
         start = 1'b0;
         chk("start_with_done_busy", int'(busy), 0);
         chk("start_with_done_re", int'(wt_re), 0);
         repeat (4) @(negedge clk);
         chk("single_done", done_cnt - d0, 1);
         chk("idle_after_pass", int'(busy), 0);
      end
   endtask

   initial begin
      vec_t rv;
      // sp, ea, os, uc, um, us, ub, load, pre, tgt, exp_tgt (when drawn < prob)
      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 7'd127, 7'd127, 7'd127, 7'd127, 1'b1, 3'd3, 0, 3'd3};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 7'd127, 7'd127, 7'd127, 7'd127, 1'b1, 3'd3, 9, 3'd4};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 7'd127, 7'd0,   7'd0,   7'd0,   1'b1, 3'd7, 2, 3'd7};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 7'd0,   7'd0,   7'd0,   7'd127, 1'b0, 3'd7, 4, 3'd6};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 7'd0,   7'd0,   7'd0,   7'd127, 1'b1, 3'd0, 4, 3'd0};
      vecs[5] = '{16'h0001, 16'h0000, 1'b0, 7'd0,   7'd0,   7'd127, 7'd0,   1'b1, 3'd3, 0, 3'd4};
      vecs[6] = '{16'h0008, 16'h0000, 1'b1, 7'd0,   7'd127, 7'd0,   7'd0,   1'b1, 3'd3, 3, 3'd2};
      vecs[7] = '{16'hFFDF, 16'h0000, 1'b1, 7'd0,   7'd0,   7'd0,   7'd127, 1'b1, 3'd3, 5, 3'd2};

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_re", int'(wt_re), 0);
      chk("rst_we", int'(wt_we), 0);
      chk("rst_addr", int'(wt_addr), 0);
      chk("rst_lfsr", int'(dut.lfsr), 'h5A);
      rst_n = 1'b1;

      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (vecs[t].load) preload(vecs[t].pre);
         run_pass(vecs[t], 1'b0);
         // prob is 127 wherever the target updates, so only draw 127 misses
         chk($sformatf("tgt_v%0d", t), int'(ram[vecs[t].tgt]),
             (m_draw[vecs[t].tgt] == 7'h7F) ? int'(vecs[t].pre) : int'(vecs[t].exp_tgt));
      end

      // extra starts mid-pass and with done; inputs scrambled after the latch
      @(negedge clk);
      preload(3'd3);
      run_pass(vecs[1], 1'b1);

      // reset asserted during WRITE of synapse 7
      @(negedge clk);
      preload(3'd3);
      rv = vecs[1];
      plan_pass(rv);
      drive_inputs(rv);
      rd_expect = 0;
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid_write_addr", int'(wt_addr), 7);
      chk("mid_write_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_we", int'(wt_we), 0);
      chk("midrst_re", int'(wt_re), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_lfsr", int'(dut.lfsr), 'h5A);
      exp_q.delete();
      m_lfsr = 7'h5A;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      preload(3'd3);
      run_pass(vecs[1], 1'b0);

      // LFSR frozen while idle
      repeat (6) @(negedge clk);
      chk("lfsr_idle_hold", int'(dut.lfsr), int'(m_lfsr));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
